mcu_ldst_responder: RTL and testbench
=====================================

Name: mcu_ldst_responder

Overview:
M_CU front-end that terminates the scheduler's load/store handshakes and walks the element addresses of a vector memory op.
- Accepts one load or store descriptor at a time: base, stride, width, addressing mode.
- Issues one memory request per element.
- For loads, counts returned beats and raises mcu_ld_buffered_o once all data is buffered, which releases the scheduler to issue the load to V_CU.

Parameters:
VL_W, 8, width of element-count input vl_i (max 255 elements)
ADDR_W, 32, address / stride / offset width

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous assert, active-low
vl_i  in  VL_W  element count, sampled at descriptor accept
mcu_ld_vld_i  in  1  scheduler load descriptor valid
mcu_ld_rdy_o  out  1  load descriptor ready
mcu_ld_buffered_o  out  1  all elements of last accepted load returned
mcu_st_vld_i  in  1  scheduler store descriptor valid
mcu_st_rdy_o  out  1  store descriptor ready
mcu_base_addr_i  in  ADDR_W  base address (rs1)
mcu_stride_i  in  ADDR_W  byte stride (rs2)
mcu_data_width_i  in  3  RVV width field: 000=8b, 101=16b, 110=32b, other=32b
mcu_unit_ld_st_i  in  1  unit-stride mode
mcu_strided_ld_st_i  in  1  strided mode
mcu_idx_ld_st_i  in  1  indexed mode
idx_offset_i  in  ADDR_W  per-element byte offset (indexed mode)
idx_offset_vld_i  in  1  offset valid
idx_offset_rdy_o  out  1  offset consumed this cycle
mem_req_vld_o  out  1  memory request valid
mem_req_rdy_i  in  1  memory request ready
mem_req_addr_o  out  ADDR_W  element byte address
mem_req_we_o  out  1  1=store, 0=load
mem_req_size_o  out  2  0=1B, 1=2B, 2=4B
mem_rsp_vld_i  in  1  one load element returned (in order, 1 pulse/element)

Behaviour:
Reset values:
- state=IDLE; all counters, address regs and buffered_reg cleared.
- Outputs: mcu_ld_rdy_o=1, mcu_st_rdy_o=!mcu_ld_vld_i, mcu_ld_buffered_o=0, mem_req_vld_o=0, idx_offset_rdy_o=0, mem_req_addr_o=0, mem_req_we_o=0, mem_req_size_o=0.
- Async reset mid-operation aborts the op. Late mem_rsp_vld_i pulses after reset are ignored, since rsp_cnt only counts in LD_WAIT/LD_ISSUE.

States: IDLE, LD_ISSUE, LD_WAIT, ST_ISSUE.

Descriptor accept (IDLE only):
- mcu_ld_rdy_o = (state==IDLE); mcu_st_rdy_o = (state==IDLE) && !mcu_ld_vld_i.
- Load has priority when both are valid.
- On accept, register vl, mode, width-derived size and ebytes (1/2/4), base, stride. Clear issue counter iss_cnt and response counter rsp_cnt.
- Next state: LD_ISSUE or ST_ISSUE.
- vl==0: load goes IDLE→LD_WAIT→buffered set the next cycle; store returns to IDLE the next cycle with no requests.

Address generation (element i):
- unit: base + i*ebytes.
- strided: base + i*stride.
- indexed: base + idx_offset_i.
- Implemented with a running accumulator advanced on each request handshake. No multiplier.
- All arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Mode priority if several flags are set: idx > strided > unit.

Request issue:
- In LD_ISSUE/ST_ISSUE, mem_req_vld_o=1, except in indexed mode where it requires idx_offset_vld_i.
- idx_offset_rdy_o = mem_req_vld_o && mem_req_rdy_i && idx mode.
- mem_req_we_o=1 only in ST_ISSUE.
- Address and size are stable while vld && !rdy.
- iss_cnt increments per handshake. On the handshake with iss_cnt==vl-1: LD_ISSUE→LD_WAIT, ST_ISSUE→IDLE.

Load responses:
- rsp_cnt increments on each mem_rsp_vld_i in LD_ISSUE/LD_WAIT; responses may overlap issue.
- In LD_WAIT, when rsp_cnt reaches vl (including a pulse arriving this cycle), set buffered_reg and return to IDLE.

Buffered flag:
- buffered_reg is held high until the next load descriptor is accepted, then cleared.
- mcu_ld_buffered_o = buffered_reg && !(state==IDLE && mcu_ld_vld_i). The flag therefore drops in the accept cycle, so a following load cannot be released early.
- Store accept does not affect buffered_reg.

Test Plan:
- Unit load: vl=4, width=110, base=0x1000, mem_req_rdy_i=1, responses 2 cycles after each request -> addrs 0x1000,0x1004,0x1008,0x100C, size=2, we=0; buffered=1 the cycle after the 4th response; ld_rdy low from accept until return to IDLE.
- Strided store with backpressure: vl=3, width=000, base=0x2000, stride=0x10, mem_req_rdy_i toggling -> addrs 0x2000,0x2010,0x2020, we=1, size=0; addr stable while stalled; st_rdy returns the cycle after the 3rd handshake; buffered unchanged.
- Indexed load: vl=3, base=0x100, offsets 0x8,0x0,0x40 with idx_offset_vld_i gaps -> addrs 0x108,0x100,0x140; no request in cycles without a valid offset; idx_offset_rdy_o pulses exactly 3 times.
- Simultaneous ld and st valid in IDLE -> load accepted, st_rdy_o=0; store accepted after the load completes. Second load accept drops buffered in the same cycle.
- vl=0 load -> no mem requests, buffered=1 two cycles after accept. Wrap: base=0xFFFFFFFC, unit, vl=2, width=110 -> addrs 0xFFFFFFFC, 0x00000000.
- Async reset asserted in LD_WAIT with 2 of 4 responses returned -> all outputs at reset values immediately. After release, stale responses are ignored and a new load completes normally.

Source files
------------

// File: rtl/mcu_ldst_responder.sv
// M_CU load/store front-end: accepts one vector memory descriptor, walks its
// element addresses one request at a time and counts returned load beats.
module mcu_ldst_responder #(
  parameter int VL_W   = 8,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [VL_W-1:0]   vl_i,
  input  logic              mcu_ld_vld_i,
  output logic              mcu_ld_rdy_o,
  output logic              mcu_ld_buffered_o,
  input  logic              mcu_st_vld_i,
  output logic              mcu_st_rdy_o,
  input  logic [ADDR_W-1:0] mcu_base_addr_i,
  input  logic [ADDR_W-1:0] mcu_stride_i,
  input  logic [2:0]        mcu_data_width_i,
  input  logic              mcu_unit_ld_st_i,
  input  logic              mcu_strided_ld_st_i,
  input  logic              mcu_idx_ld_st_i,
  input  logic [ADDR_W-1:0] idx_offset_i,
  input  logic              idx_offset_vld_i,
  output logic              idx_offset_rdy_o,
  output logic              mem_req_vld_o,
  input  logic              mem_req_rdy_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic              mem_req_we_o,
  output logic [1:0]        mem_req_size_o,
  input  logic              mem_rsp_vld_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LD_ISSUE = 2'd1,
    LD_WAIT  = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

  localparam logic [VL_W-1:0] VL_ZERO = {VL_W{1'b0}};
  localparam logic [VL_W-1:0] VL_ONE  = {{(VL_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [VL_W-1:0]   r_vl;
  logic [VL_W-1:0]   r_iss_cnt;
  logic [VL_W-1:0]   r_rsp_cnt;
  logic              r_idx;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_acc;
  logic [ADDR_W-1:0] r_inc;
  logic              r_buffered;

  logic              w_idle;
  logic              w_issuing;
  logic              w_ld_acc;
  logic              w_st_acc;
  logic              w_hs;
  logic              w_last_iss;
  logic              w_count_rsp;
  logic              w_rsp_done;
  logic [VL_W-1:0]   w_rsp_next;
  logic [1:0]        w_size_dec;
  logic [ADDR_W-1:0] w_ebytes;

  assign w_idle       = (r_state == IDLE);
  assign mcu_ld_rdy_o = w_idle;
  assign mcu_st_rdy_o = w_idle && !mcu_ld_vld_i;
  assign w_ld_acc     = w_idle && mcu_ld_vld_i;
  assign w_st_acc     = mcu_st_rdy_o && mcu_st_vld_i;

  // A zero-length op sits in its issue state for one cycle without requesting.
  assign w_issuing        = ((r_state == LD_ISSUE) || (r_state == ST_ISSUE)) && (r_vl != VL_ZERO);
  assign mem_req_vld_o    = w_issuing && (!r_idx || idx_offset_vld_i);
  assign w_hs             = mem_req_vld_o && mem_req_rdy_i;
  assign idx_offset_rdy_o = w_hs && r_idx;
  assign mem_req_addr_o   = r_idx ? (r_base + idx_offset_i) : r_acc;
  assign mem_req_we_o     = (r_state == ST_ISSUE);
  assign mem_req_size_o   = r_size;
  assign w_last_iss       = (r_iss_cnt == (r_vl - VL_ONE));

  assign w_count_rsp = mem_rsp_vld_i && ((r_state == LD_ISSUE) || (r_state == LD_WAIT));
  assign w_rsp_next  = w_count_rsp ? (r_rsp_cnt + VL_ONE) : r_rsp_cnt;
  assign w_rsp_done  = (r_state == LD_WAIT) && (w_rsp_next >= r_vl);

  assign mcu_ld_buffered_o = r_buffered && !w_ld_acc;

  // Decode the RVV width field into request size and per-element byte step.
  always_comb begin
    w_size_dec = 2'd2;
    w_ebytes   = ADDR_W'(3'd4);
    case (mcu_data_width_i)
      3'b000: begin
        w_size_dec = 2'd0;
        w_ebytes   = ADDR_W'(3'd1);
      end
      3'b101: begin
        w_size_dec = 2'd1;
        w_ebytes   = ADDR_W'(3'd2);
      end
      default: begin
        w_size_dec = 2'd2;
        w_ebytes   = ADDR_W'(3'd4);
      end
    endcase
  end

  // Descriptor capture, element walk and response counting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_vl       <= VL_ZERO;
      r_iss_cnt  <= VL_ZERO;
      r_rsp_cnt  <= VL_ZERO;
      r_idx      <= 1'b0;
      r_size     <= 2'd0;
      r_base     <= {ADDR_W{1'b0}};
      r_acc      <= {ADDR_W{1'b0}};
      r_inc      <= {ADDR_W{1'b0}};
      r_buffered <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ld_acc || w_st_acc) begin
            r_vl      <= vl_i;
            r_idx     <= mcu_idx_ld_st_i;
            r_size    <= w_size_dec;
            r_base    <= mcu_base_addr_i;
            r_acc     <= mcu_base_addr_i;
            // Strided wins over unit; indexed ignores the accumulator entirely.
            r_inc     <= (!mcu_idx_ld_st_i && mcu_strided_ld_st_i) ? mcu_stride_i : w_ebytes;
            r_iss_cnt <= VL_ZERO;
            r_rsp_cnt <= VL_ZERO;
            if (w_ld_acc) begin
              r_buffered <= 1'b0;
              r_state    <= (vl_i == VL_ZERO) ? LD_WAIT : LD_ISSUE;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        LD_ISSUE: begin
          r_rsp_cnt <= w_rsp_next;
          if (w_hs) begin
            r_iss_cnt <= r_iss_cnt + VL_ONE;
            r_acc     <= r_acc + r_inc;
            if (w_last_iss) begin
              r_state <= LD_WAIT;
            end
          end
        end
        LD_WAIT: begin
          r_rsp_cnt <= w_rsp_next;
          if (w_rsp_done) begin
            r_buffered <= 1'b1;
            r_state    <= IDLE;
          end
        end
        ST_ISSUE: begin
          if (r_vl == VL_ZERO) begin
            r_state <= IDLE;
          end else if (w_hs) begin
            r_iss_cnt <= r_iss_cnt + VL_ONE;
            r_acc     <= r_acc + r_inc;
            if (w_last_iss) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_ldst_responder.sv
// Self-checking bench for mcu_ldst_responder: directed scenarios plus randomized
// ops checked against an element-list model computed with plain arithmetic.
module tb_mcu_ldst_responder;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  vl_i = 8'd0;
  logic        mcu_ld_vld_i = 1'b0;
  logic        mcu_ld_rdy_o;
  logic        mcu_ld_buffered_o;
  logic        mcu_st_vld_i = 1'b0;
  logic        mcu_st_rdy_o;
  logic [31:0] mcu_base_addr_i = 32'd0;
  logic [31:0] mcu_stride_i = 32'd0;
  logic [2:0]  mcu_data_width_i = 3'd0;
  logic        mcu_unit_ld_st_i = 1'b0;
  logic        mcu_strided_ld_st_i = 1'b0;
  logic        mcu_idx_ld_st_i = 1'b0;
  logic [31:0] idx_offset_i = 32'd0;
  logic        idx_offset_vld_i = 1'b0;
  logic        idx_offset_rdy_o;
  logic        mem_req_vld_o;
  logic        mem_req_rdy_i = 1'b0;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_we_o;
  logic [1:0]  mem_req_size_o;
  logic        mem_rsp_vld_i = 1'b0;

  int          total = 0;
  int          bad = 0;
  logic        exp_buf = 1'b0;
  logic [31:0] dir_off[$];

  mcu_ldst_responder #(.VL_W(8), .ADDR_W(32)) dut (
    .clk(clk), .rstn(rstn), .vl_i(vl_i),
    .mcu_ld_vld_i(mcu_ld_vld_i), .mcu_ld_rdy_o(mcu_ld_rdy_o),
    .mcu_ld_buffered_o(mcu_ld_buffered_o),
    .mcu_st_vld_i(mcu_st_vld_i), .mcu_st_rdy_o(mcu_st_rdy_o),
    .mcu_base_addr_i(mcu_base_addr_i), .mcu_stride_i(mcu_stride_i),
    .mcu_data_width_i(mcu_data_width_i), .mcu_unit_ld_st_i(mcu_unit_ld_st_i),
    .mcu_strided_ld_st_i(mcu_strided_ld_st_i), .mcu_idx_ld_st_i(mcu_idx_ld_st_i),
    .idx_offset_i(idx_offset_i), .idx_offset_vld_i(idx_offset_vld_i),
    .idx_offset_rdy_o(idx_offset_rdy_o),
    .mem_req_vld_o(mem_req_vld_o), .mem_req_rdy_i(mem_req_rdy_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_we_o(mem_req_we_o),
    .mem_req_size_o(mem_req_size_o), .mem_rsp_vld_i(mem_rsp_vld_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_ld_rdy"}, 32'(mcu_ld_rdy_o), 32'd1);
    chk({pfx, "_st_rdy"}, 32'(mcu_st_rdy_o), 32'(!mcu_ld_vld_i));
    chk({pfx, "_buf"}, 32'(mcu_ld_buffered_o), 32'd0);
    chk({pfx, "_req_vld"}, 32'(mem_req_vld_o), 32'd0);
    chk({pfx, "_idx_rdy"}, 32'(idx_offset_rdy_o), 32'd0);
    chk({pfx, "_addr"}, mem_req_addr_o, 32'd0);
    chk({pfx, "_we"}, 32'(mem_req_we_o), 32'd0);
    chk({pfx, "_size"}, 32'(mem_req_size_o), 32'd0);
  endtask

  // mode: 0=unit, 1=strided, 2=indexed. rsp_dly 0 picks a random delay per element.
  task automatic run_op(input bit is_ld, input int mode, input int vl, input logic [31:0] base,
                        input logic [31:0] stride, input logic [2:0] width, input int rdy_pct,
                        input int rsp_dly, input int ovld_pct, input bit both_vld);
    logic [31:0] exp_addr[$];
    logic [31:0] offs[$];
    logic [31:0] off;
    int          sched[$];
    int          eb, sz, iss, rsp_sent, k, done_k, last_sched, t, idx_pulses;
    bit          rdy_d, ovld_d, rsp_d, exp_vld;
    eb = (width == 3'b000) ? 1 : (width == 3'b101) ? 2 : 4;
    sz = (eb == 1) ? 0 : (eb == 2) ? 1 : 2;
    for (int i = 0; i < vl; i++) begin
      off = (dir_off.size() > 0) ? dir_off.pop_front() : $urandom;
      offs.push_back(off);
      if (mode == 2)      exp_addr.push_back(base + off);
      else if (mode == 1) exp_addr.push_back(base + 32'(i) * stride);
      else                exp_addr.push_back(base + 32'(i) * 32'(eb));
    end
    @(posedge clk); #1;
    vl_i = 8'(vl);
    mcu_base_addr_i = base;
    mcu_stride_i = stride;
    mcu_data_width_i = width;
    mcu_unit_ld_st_i    = (mode == 0) ? 1'b1 : 1'($urandom_range(1));
    mcu_strided_ld_st_i = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(1)) : 1'b0;
    mcu_idx_ld_st_i     = (mode == 2);
    mcu_ld_vld_i = is_ld;
    mcu_st_vld_i = !is_ld || both_vld;
    @(negedge clk);
    chk("desc_ld_rdy", 32'(mcu_ld_rdy_o), 32'd1);
    chk("desc_st_rdy", 32'(mcu_st_rdy_o), 32'(!is_ld));
    chk("desc_buf", 32'(mcu_ld_buffered_o), is_ld ? 32'd0 : 32'(exp_buf));
    @(posedge clk); #1;
    mcu_ld_vld_i = 1'b0;
    mcu_st_vld_i = 1'b0;
    if (is_ld) exp_buf = 1'b0;
    iss = 0; rsp_sent = 0; k = 0; last_sched = -1; idx_pulses = 0;
    done_k = (vl == 0) ? 1 : -1;
    while (1) begin
      rdy_d  = ($urandom_range(99) < 32'(rdy_pct));
      ovld_d = ($urandom_range(99) < 32'(ovld_pct));
      mem_req_rdy_i    = rdy_d;
      idx_offset_vld_i = ovld_d;
      idx_offset_i     = (iss < vl) ? offs[iss] : $urandom;
      rsp_d = (sched.size() > 0) && (sched[0] == k);
      if (rsp_d) begin
        void'(sched.pop_front());
        rsp_sent++;
        if (rsp_sent == vl) done_k = k + 1;
      end
      mem_rsp_vld_i = rsp_d;
      @(negedge clk);
      if (k == done_k) begin
        if (is_ld) exp_buf = 1'b1;
        chk("done_ld_rdy", 32'(mcu_ld_rdy_o), 32'd1);
        chk("done_st_rdy", 32'(mcu_st_rdy_o), 32'd1);
        chk("done_buf", 32'(mcu_ld_buffered_o), 32'(exp_buf));
        chk("done_req_vld", 32'(mem_req_vld_o), 32'd0);
        chk("done_idx_rdy", 32'(idx_offset_rdy_o), 32'd0);
        if (mode == 2) chk("idx_pulses", 32'(idx_pulses), 32'(vl));
        break;
      end
      exp_vld = (iss < vl) && ((mode != 2) || ovld_d);
      chk("busy_ld_rdy", 32'(mcu_ld_rdy_o), 32'd0);
      chk("busy_buf", 32'(mcu_ld_buffered_o), 32'(exp_buf));
      chk("req_vld", 32'(mem_req_vld_o), 32'(exp_vld));
      chk("idx_rdy", 32'(idx_offset_rdy_o), 32'(exp_vld && rdy_d && (mode == 2)));
      if (idx_offset_rdy_o) idx_pulses++;
      if (exp_vld) begin
        chk("req_addr", mem_req_addr_o, exp_addr[iss]);
        chk("req_we", 32'(mem_req_we_o), 32'(!is_ld));
        chk("req_size", 32'(mem_req_size_o), 32'(sz));
        if (rdy_d) begin
          iss++;
          if (is_ld) begin
            t = k + ((rsp_dly > 0) ? rsp_dly : int'($urandom_range(4, 1)));
            if (t <= last_sched) t = last_sched + 1;
            sched.push_back(t);
            last_sched = t;
          end else if (iss == vl) begin
            done_k = k + 1;
          end
        end
      end
      if (k > 3000) begin
        chk("op_timeout", 32'(k), 32'd0);
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    mem_req_rdy_i = 1'b0;
    idx_offset_vld_i = 1'b0;
    mem_rsp_vld_i = 1'b0;
  endtask

  initial begin
    #3;
    chk_reset_outs("rst0");
    @(negedge clk);
    rstn = 1'b1;

    // unit load, always ready, responses two cycles after each request
    run_op(1'b1, 0, 4, 32'h0000_1000, 32'd0, 3'b110, 100, 2, 100, 1'b0);
    // strided byte store with backpressure; buffered flag must stay high
    run_op(1'b0, 1, 3, 32'h0000_2000, 32'h10, 3'b000, 50, 0, 100, 1'b0);
    // indexed load with offset-valid gaps
    dir_off.push_back(32'h8);
    dir_off.push_back(32'h0);
    dir_off.push_back(32'h40);
    run_op(1'b1, 2, 3, 32'h0000_0100, 32'd0, 3'b110, 70, 0, 50, 1'b0);
    // simultaneous ld/st valid: load wins and buffered drops in the accept cycle
    run_op(1'b1, 0, 2, 32'h0000_4000, 32'd0, 3'b101, 100, 1, 100, 1'b1);
    run_op(1'b0, 0, 2, 32'h0000_5000, 32'd0, 3'b101, 100, 0, 100, 1'b0);
    // zero-length ops
    run_op(1'b1, 0, 0, 32'h0000_6000, 32'd0, 3'b110, 100, 0, 100, 1'b0);
    run_op(1'b0, 1, 0, 32'h0000_7000, 32'h4, 3'b110, 100, 0, 100, 1'b0);
    // address wrap-around
    run_op(1'b1, 0, 2, 32'hFFFF_FFFC, 32'd0, 3'b110, 100, 2, 100, 1'b0);

    // async reset during LD_WAIT with 2 of 4 responses returned
    @(posedge clk); #1;
    vl_i = 8'd4; mcu_base_addr_i = 32'h0000_3000; mcu_data_width_i = 3'b110;
    mcu_unit_ld_st_i = 1'b1; mcu_strided_ld_st_i = 1'b0; mcu_idx_ld_st_i = 1'b0;
    mcu_ld_vld_i = 1'b1; mem_req_rdy_i = 1'b1;
    @(posedge clk); #1;
    mcu_ld_vld_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    mem_req_rdy_i = 1'b0;
    mem_rsp_vld_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_rsp_vld_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(mcu_ld_rdy_o), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    mcu_ld_vld_i = 1'b1;
    #1;
    chk("rst_mid_st_rdy_ldv", 32'(mcu_st_rdy_o), 32'd0);
    chk("rst_mid_buf_ldv", 32'(mcu_ld_buffered_o), 32'd0);
    mcu_ld_vld_i = 1'b0;
    exp_buf = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    mem_rsp_vld_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mem_rsp_vld_i = 1'b0;
    @(negedge clk);
    chk("stale_rsp_idle", 32'(mcu_ld_rdy_o), 32'd1);
    chk("stale_rsp_buf", 32'(mcu_ld_buffered_o), 32'd0);
    run_op(1'b1, 0, 4, 32'h0000_8000, 32'd0, 3'b110, 100, 2, 100, 1'b0);

    // randomized ops
    for (int n = 0; n < 24; n++) begin
      run_op(1'($urandom_range(1)), int'($urandom_range(2)), int'($urandom_range(12)),
             $urandom, $urandom, 3'($urandom_range(7)), int'($urandom_range(100, 30)),
             0, int'($urandom_range(100, 30)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
